// File: rtl/multicycle_control_fsm.sv
// Control FSM for a multi-cycle RV32I core. It sequences fetch, decode, execute,
// memory and writeback over one shared memory port, and traps on illegal opcodes or memory timeouts.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        IMM_UNKNOWN_TYPE = 3'd0,
        IMM_I_TYPE       = 3'd1,
        IMM_S_TYPE       = 3'd2,
        IMM_B_TYPE       = 3'd3,
        IMM_U_TYPE       = 3'd4,
        IMM_J_TYPE       = 3'd5
    } imm_select_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

module multicycle_control_fsm
    import multicycle_control_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] instr_i,
    input  logic            branch_taken_i,
    input  logic            mem_ready_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic            mem_instr_o,
    output logic            ir_we_o,
    output logic            pc_we_o,
    output logic            pc_sel_o,
    output imm_select_e     imm_sel_o,
    output logic [1:0]      alu_src_a_o,
    output logic            alu_src_b_o,
    output logic            alu_op_o,
    output logic            rf_we_o,
    output logic [1:0]      wb_sel_o,
    output logic            trap_o,
    output logic [1:0]      trap_cause_o
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cause_q, cause_d;
    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_expire;

    logic [6:0]  opcode;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic        is_load, is_store, is_op_imm, is_op, is_fence, is_legal;
    imm_select_e imm_dec;
    logic [1:0]  src_a_dec;
    logic        src_b_dec, alu_op_dec;
    logic        unused_instr_bits;

    assign opcode            = instr_i[6:0];
    assign unused_instr_bits = ^instr_i[XLEN-1:7];

    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_op     = (opcode == OPC_OP);
    assign is_fence  = (opcode == OPC_MISC_MEM);
    assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load |
                       is_store | is_op_imm | is_op | is_fence;

    // Instruction-dependent selects; the FSM below decides in which states they are visible.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        imm_dec    = IMM_UNKNOWN_TYPE;
        src_a_dec  = ALU_A_RS1;
        src_b_dec  = 1'b0;
        alu_op_dec = 1'b0;
        if (is_lui || is_auipc)                 imm_dec = IMM_U_TYPE;
        else if (is_jal)                        imm_dec = IMM_J_TYPE;
        else if (is_jalr || is_load || is_op_imm) imm_dec = IMM_I_TYPE;
        else if (is_branch)                     imm_dec = IMM_B_TYPE;
        else if (is_store)                      imm_dec = IMM_S_TYPE;

        if (is_op) begin
            alu_op_dec = 1'b1;
        end else if (is_op_imm) begin
            src_b_dec  = 1'b1;
            alu_op_dec = 1'b1;
        end else if (is_lui) begin
            src_a_dec = ALU_A_ZERO;
            src_b_dec = 1'b1;
        end else if (is_auipc || is_jal || is_branch) begin
            src_a_dec = ALU_A_PC;
            src_b_dec = 1'b1;
        end else if (is_load || is_store || is_jalr) begin
            src_b_dec = 1'b1;
        end
    end

    // The watchdog fires on the cycle whose stall would make the wait count reach TIMEOUT_CYC.
    assign wd_expire = (TIMEOUT_CYC != 0) && ((state_q == S_FETCH) || (state_q == S_MEM)) &&
                       !mem_ready_i && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_instr_o  = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_sel_o     = 1'b0;
        imm_sel_o    = IMM_UNKNOWN_TYPE;
        alu_src_a_o  = ALU_A_RS1;
        alu_src_b_o  = 1'b0;
        alu_op_o     = 1'b0;
        rf_we_o      = 1'b0;
        wb_sel_o     = WB_ALU;
        trap_o       = (state_q == S_TRAP);
        trap_cause_o = cause_q;

        if (state_q inside {S_DECODE, S_EXECUTE, S_MEM, S_WB}) imm_sel_o = imm_dec;
        if (state_q inside {S_EXECUTE, S_MEM, S_WB}) begin
            alu_src_a_o = src_a_dec;
            alu_src_b_o = src_b_dec;
            alu_op_o    = alu_op_dec;
        end

        unique case (state_q)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                mem_instr_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    pc_we_o  = 1'b1;
                    pc_sel_o = branch_taken_i;
                    state_d  = S_FETCH;
                end else if (is_fence) begin
                    pc_we_o = 1'b1;
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = is_store;
                if (mem_ready_i) begin
                    if (is_store) begin
                        pc_we_o = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                rf_we_o  = 1'b1;
                pc_we_o  = 1'b1;
                pc_sel_o = is_jal || is_jalr;
                if (is_load)                wb_sel_o = WB_MEM;
                else if (is_jal || is_jalr) wb_sel_o = WB_PC4;
                state_d  = S_FETCH;
            end
            default: ;
        endcase

        // Reset kills an in-flight fetch request without waiting for a clock edge.
        if (!rst_ni) begin
            mem_req_o   = 1'b0;
            mem_instr_o = 1'b0;
            ir_we_o     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Wait counter: any cycle that is not a continuing stall in FETCH/MEM clears it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt_q <= '0;
        end else if ((TIMEOUT_CYC != 0) && (state_q inside {S_FETCH, S_MEM}) &&
                     !mem_ready_i && (state_d == state_q)) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_q <= '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle expectations are queued by the
// stimulus process and compared against the DUT outputs by an independent monitor.
module tb_multicycle_control_fsm;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       instr;
        logic       ir_we;
        logic       pc_we;
        logic       pc_sel;
        logic [2:0] imm;
        logic [1:0] a;
        logic       b;
        logic       op;
        logic       rf_we;
        logic [1:0] wb;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LW    = 32'h0000_2103;
    localparam logic [31:0] I_SW    = 32'h0020_2223;
    localparam logic [31:0] I_BEQ   = 32'h0000_0463;
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;
    localparam logic [31:0] I_LUI   = 32'h1234_50B7;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_FENCE = 32'h0000_000F;
    localparam logic [31:0] I_ECALL = 32'h0000_0073;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, mem_instr, ir_we, pc_we, pc_sel;
    imm_select_e imm_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b, alu_op, rf_we;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [1:0]  trap_cause;

    ctl_t  act;
    ctl_t  e;
    ctl_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    multicycle_control_fsm #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_i        (instr),
        .branch_taken_i (branch_taken),
        .mem_ready_i    (mem_ready),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_instr_o    (mem_instr),
        .ir_we_o        (ir_we),
        .pc_we_o        (pc_we),
        .pc_sel_o       (pc_sel),
        .imm_sel_o      (imm_sel),
        .alu_src_a_o    (alu_src_a),
        .alu_src_b_o    (alu_src_b),
        .alu_op_o       (alu_op),
        .rf_we_o        (rf_we),
        .wb_sel_o       (wb_sel),
        .trap_o         (trap),
        .trap_cause_o   (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        act        = '0;
        act.req    = mem_req;
        act.we     = mem_we;
        act.instr  = mem_instr;
        act.ir_we  = ir_we;
        act.pc_we  = pc_we;
        act.pc_sel = pc_sel;
        act.imm    = imm_sel;
        act.a      = alu_src_a;
        act.b      = alu_src_b;
        act.op     = alu_op;
        act.rf_we  = rf_we;
        act.wb     = wb_sel;
        act.trap   = trap;
        act.cause  = trap_cause;
    end

    task automatic check(input string name, input ctl_t got, input ctl_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: actual req=%b we=%b instr=%b ir_we=%b pc_we=%b pc_sel=%b imm=%0d a=%0d b=%b op=%b rf_we=%b wb=%0d trap=%b cause=%0d | required req=%b we=%b instr=%b ir_we=%b pc_we=%b pc_sel=%b imm=%0d a=%0d b=%b op=%b rf_we=%b wb=%0d trap=%b cause=%0d",
                     name, got.req, got.we, got.instr, got.ir_we, got.pc_we, got.pc_sel, got.imm,
                     got.a, got.b, got.op, got.rf_we, got.wb, got.trap, got.cause,
                     want.req, want.we, want.instr, want.ir_we, want.pc_we, want.pc_sel, want.imm,
                     want.a, want.b, want.op, want.rf_we, want.wb, want.trap, want.cause);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  want;
            string nm;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            check(nm, act, want);
        end
    end

    function automatic ctl_t x_fetch(input logic rdy);
        ctl_t r;
        r       = '0;
        r.req   = 1'b1;
        r.instr = 1'b1;
        r.ir_we = rdy;
        return r;
    endfunction

    function automatic ctl_t x_dec(input logic [2:0] imm);
        ctl_t r;
        r     = '0;
        r.imm = imm;
        return r;
    endfunction

    function automatic ctl_t x_exe(input logic [2:0] imm, input logic [1:0] a, input logic b,
                                   input logic op);
        ctl_t r;
        r    = x_dec(imm);
        r.a  = a;
        r.b  = b;
        r.op = op;
        return r;
    endfunction

    function automatic ctl_t x_trap(input logic [1:0] cause);
        ctl_t r;
        r       = '0;
        r.trap  = 1'b1;
        r.cause = cause;
        return r;
    endfunction

    // One clock cycle of stimulus: drive inputs, queue what the DUT must show this cycle.
    task automatic cyc(input logic rdy, input logic taken, input ctl_t want, input string name);
        mem_ready    = rdy;
        branch_taken = taken;
        exp_q.push_back(want);
        name_q.push_back(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        instr        = 32'h0;
        mem_ready    = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, '0, "reset_state");
        rst_n = 1'b1;

        // Abort a stalled fetch with reset; the watchdog must restart from zero afterwards.
        cyc(1'b0, 1'b0, x_fetch(1'b0), "fetch_wait_a");
        cyc(1'b0, 1'b0, x_fetch(1'b0), "fetch_wait_b");
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0, "rst_mid_fetch");
        rst_n = 1'b1;

        instr = I_ADDI;
        repeat (3) cyc(1'b0, 1'b0, x_fetch(1'b0), "fetch_wd_cleared");
        cyc(1'b1, 1'b0, x_fetch(1'b1), "addi_fetch_4th_ready");
        cyc(1'b0, 1'b0, x_dec(IMM_I_TYPE), "addi_decode");
        e = x_exe(IMM_I_TYPE, ALU_A_RS1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, e, "addi_exec");
        e.rf_we = 1'b1; e.pc_we = 1'b1;
        cyc(1'b0, 1'b0, e, "addi_wb");

        instr = I_LW;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "lw_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_I_TYPE), "lw_decode");
        e = x_exe(IMM_I_TYPE, ALU_A_RS1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, e, "lw_exec");
        e.req = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, e, "lw_mem_wait");
        cyc(1'b1, 1'b0, e, "lw_mem_ready_4th");
        e.req = 1'b0; e.rf_we = 1'b1; e.wb = WB_MEM; e.pc_we = 1'b1;
        cyc(1'b0, 1'b0, e, "lw_wb");

        instr = I_SW;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "sw_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_S_TYPE), "sw_decode");
        e = x_exe(IMM_S_TYPE, ALU_A_RS1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, e, "sw_exec");
        e.req = 1'b1; e.we = 1'b1; e.pc_we = 1'b1;
        cyc(1'b1, 1'b0, e, "sw_mem");

        instr = I_BEQ;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "beq_t_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_B_TYPE), "beq_t_decode");
        e = x_exe(IMM_B_TYPE, ALU_A_PC, 1'b1, 1'b0);
        e.pc_we = 1'b1; e.pc_sel = 1'b1;
        cyc(1'b0, 1'b1, e, "beq_taken_exec");
        cyc(1'b1, 1'b0, x_fetch(1'b1), "beq_n_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_B_TYPE), "beq_n_decode");
        e.pc_sel = 1'b0;
        cyc(1'b0, 1'b0, e, "beq_not_taken_exec");

        instr = I_JAL;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "jal_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_J_TYPE), "jal_decode");
        e = x_exe(IMM_J_TYPE, ALU_A_PC, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, e, "jal_exec");
        e.rf_we = 1'b1; e.wb = WB_PC4; e.pc_we = 1'b1; e.pc_sel = 1'b1;
        cyc(1'b0, 1'b0, e, "jal_wb");

        instr = I_LUI;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "lui_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_U_TYPE), "lui_decode");
        e = x_exe(IMM_U_TYPE, ALU_A_ZERO, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, e, "lui_exec");
        e.rf_we = 1'b1; e.pc_we = 1'b1;
        cyc(1'b0, 1'b0, e, "lui_wb");

        instr = I_ADD;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "add_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_UNKNOWN_TYPE), "add_decode");
        e = x_exe(IMM_UNKNOWN_TYPE, ALU_A_RS1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, e, "add_exec");
        e.rf_we = 1'b1; e.pc_we = 1'b1;
        cyc(1'b0, 1'b0, e, "add_wb");

        instr = I_FENCE;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "fence_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_UNKNOWN_TYPE), "fence_decode");
        e = '0; e.pc_we = 1'b1;
        cyc(1'b0, 1'b0, e, "fence_exec");

        instr = I_ECALL;
        cyc(1'b1, 1'b0, x_fetch(1'b1), "ecall_fetch");
        cyc(1'b0, 1'b0, x_dec(IMM_UNKNOWN_TYPE), "ecall_decode");
        repeat (3) cyc(1'b1, 1'b0, x_trap(CAUSE_ILLEGAL), "ecall_trap");
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0, "rst_from_trap");
        rst_n = 1'b1;

        instr = I_ADDI;
        repeat (4) cyc(1'b0, 1'b0, x_fetch(1'b0), "timeout_fetch_wait");
        repeat (2) cyc(1'b1, 1'b0, x_trap(CAUSE_TIMEOUT), "timeout_trap");
        rst_n = 1'b0;
        cyc(1'b0, 1'b0, '0, "rst_from_timeout");
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, x_fetch(1'b0), "fetch_after_recover");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual simulation still running, required finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
